// File: rtl/y86_pkg.sv
// Shared encodings for the sequential Y86-64 control sequencer: FSM states,
// status codes, instruction codes and the instruction-length decode.
package y86_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXECUTE = 4'd3,
    S_MEMORY  = 4'd4,
    S_WRBACK  = 4'd5,
    S_PCUPD   = 4'd6,
    S_PAUSE   = 4'd7,
    S_HALTED  = 4'd8
  } state_t;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // stage_en bit order: DECODE is the MSB, PCUPD the LSB
  localparam logic [4:0] STG_DECODE  = 5'b10000;
  localparam logic [4:0] STG_EXECUTE = 5'b01000;
  localparam logic [4:0] STG_MEMORY  = 5'b00100;
  localparam logic [4:0] STG_WRBACK  = 5'b00010;
  localparam logic [4:0] STG_PCUPD   = 5'b00001;

  function automatic logic [3:0] instr_len_of(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:              instr_len_of = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:  instr_len_of = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      instr_len_of = 4'd10;
      I_JXX, I_CALL:                     instr_len_of = 4'd9;
      default:                           instr_len_of = 4'd1;
    endcase
  endfunction

  function automatic logic icode_legal(input logic [3:0] icode);
    icode_legal = (icode <= I_POPQ);
  endfunction

  function automatic logic [4:0] stage_onehot(input state_t s);
    case (s)
      S_DECODE:  stage_onehot = STG_DECODE;
      S_EXECUTE: stage_onehot = STG_EXECUTE;
      S_MEMORY:  stage_onehot = STG_MEMORY;
      S_WRBACK:  stage_onehot = STG_WRBACK;
      S_PCUPD:   stage_onehot = STG_PCUPD;
      default:   stage_onehot = 5'b00000;
    endcase
  endfunction

  function automatic logic busy_of(input state_t s);
    busy_of = !((s == S_IDLE) || (s == S_PAUSE) || (s == S_HALTED));
  endfunction

endpackage

// File: rtl/y86_fetch_buffer.sv
// Byte counter and 80-bit instruction assembly register. Exposes look-ahead
// decode of the byte currently being accepted so the sequencer can decide
// the next state in the same cycle.
module y86_fetch_buffer
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [3:0]  k,
  output logic [79:0] instr,
  output logic [3:0]  instr_len,
  output logic [3:0]  icode,
  output logic        last
);

  logic [3:0] len_eff;
  logic [6:0] bitpos;

  // Byte 0 decodes directly from the incoming data; later bytes use the stored length
  assign icode   = (k == 4'd0) ? data[7:4] : instr[79:76];
  assign len_eff = (k == 4'd0) ? instr_len_of(data[7:4]) : instr_len;
  assign last    = ((k + 4'd1) == len_eff);
  assign bitpos  = 7'd72 - {k, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= 4'd0;
      instr     <= 80'd0;
      instr_len <= 4'd1;
    end else if (clear) begin
      k     <= 4'd0;
      instr <= 80'd0;
    end else if (take) begin
      instr[bitpos +: 8] <= data;
      k                  <= k + 4'd1;
      if (k == 4'd0) begin
        instr_len <= len_eff;
      end
    end
  end

endmodule

// File: rtl/y86_seq_sequencer.sv
// Sequential Y86-64 control sequencer: walks FETCH..PCUPD once per instruction,
// fetching one byte per handshake and reporting status, PC and retire count.
module y86_seq_sequencer
  import y86_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int IMEM_BYTES = 20481,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  input  logic              imem_valid,
  output logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              dmem_err,
  input  logic              mem_op,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [79:0]       instr,
  output logic [3:0]        instr_len,
  output logic [4:0]        stage_en,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        stat,
  output logic [CNT_W-1:0]  retired,
  output logic              busy
);

  localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W + 1)'(IMEM_BYTES);

  state_t            state;
  state_t            nxt;
  logic [3:0]        stat_nxt;
  logic              fetch_go;
  logic              dmem_go;
  logic              pc_load;
  logic              ret_inc;
  logic              fb_clear;
  logic              fb_take;
  logic              step_q;
  logic              step_rise;
  logic [ADDR_W-1:0] fa_base;
  logic [3:0]        fa_off;
  logic [ADDR_W:0]   fa_sum;
  logic              fa_ok;
  logic [3:0]        fb_k;
  logic [3:0]        fb_icode;
  logic              fb_last;
  logic              adr_s;
  logic              ins_s;
  logic              hlt_s;

  y86_fetch_buffer u_fetch (
    .clk       (clk),
    .rst       (rst),
    .clear     (fb_clear),
    .take      (fb_take),
    .data      (imem_data),
    .k         (fb_k),
    .instr     (instr),
    .instr_len (instr_len),
    .icode     (fb_icode),
    .last      (fb_last)
  );

  // Carry out of the add counts as out of range, so wrapped addresses are rejected
  assign fa_sum    = {1'b0, fa_base} + {{(ADDR_W - 3){1'b0}}, fa_off};
  assign fa_ok     = (fa_sum < IMEM_LIM);
  assign fb_take   = (state == S_FETCH) && imem_rd && imem_valid;
  assign step_rise = step && !step_q;
  assign adr_s     = fb_take && !fb_last && !fa_ok;
  assign ins_s     = fb_take && !icode_legal(fb_icode);
  assign hlt_s     = fb_take && fb_last && (fb_icode == I_HALT);

  // Address of the byte the next cycle will request
  always_comb begin
    fa_base = pc;
    fa_off  = 4'd0;
    case (state)
      S_PCUPD: begin
        fa_base = pc_next;
        fa_off  = 4'd0;
      end
      S_FETCH: begin
        fa_base = pc;
        fa_off  = fb_take ? (fb_k + 4'd1) : fb_k;
      end
      default: begin
        fa_base = pc;
        fa_off  = 4'd0;
      end
    endcase
  end

  // Next-state and per-cycle action decode
  always_comb begin
    nxt      = state;
    stat_nxt = stat;
    fetch_go = 1'b0;
    dmem_go  = 1'b0;
    pc_load  = 1'b0;
    ret_inc  = 1'b0;
    fb_clear = 1'b0;
    case (state)
      S_IDLE, S_PAUSE: begin
        if ((state == S_IDLE) ? start : step_rise) begin
          if (fa_ok) begin
            nxt      = S_FETCH;
            fetch_go = 1'b1;
            fb_clear = 1'b1;
          end else begin
            nxt      = S_HALTED;
            stat_nxt = STAT_ADR;
          end
        end else begin
          nxt = state;
        end
      end
      S_FETCH: begin
        if (adr_s) begin
          nxt      = S_HALTED;
          stat_nxt = STAT_ADR;
        end else if (ins_s) begin
          nxt      = S_HALTED;
          stat_nxt = STAT_INS;
        end else if (hlt_s) begin
          nxt      = S_HALTED;
          stat_nxt = STAT_HLT;
        end else if (fb_take && fb_last) begin
          nxt = S_DECODE;
        end else begin
          fetch_go = 1'b1;
        end
      end
      S_DECODE:  nxt = S_EXECUTE;
      // mem_op is sampled here so dmem_req can be a registered output in MEMORY
      S_EXECUTE: begin
        nxt     = S_MEMORY;
        dmem_go = mem_op;
      end
      S_MEMORY: begin
        if (!dmem_req) begin
          nxt = S_WRBACK;
        end else if (dmem_ack) begin
          if (dmem_err) begin
            nxt      = S_HALTED;
            stat_nxt = STAT_ADR;
          end else begin
            nxt = S_WRBACK;
          end
        end else begin
          dmem_go = 1'b1;
        end
      end
      S_WRBACK:  nxt = S_PCUPD;
      S_PCUPD: begin
        pc_load = 1'b1;
        ret_inc = 1'b1;
        if (step_mode) begin
          nxt = S_PAUSE;
        end else if (fa_ok) begin
          nxt      = S_FETCH;
          fetch_go = 1'b1;
          fb_clear = 1'b1;
        end else begin
          nxt      = S_HALTED;
          stat_nxt = STAT_ADR;
        end
      end
      S_HALTED:  nxt = S_HALTED;
      default:   nxt = S_IDLE;
    endcase
  end

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stat      <= STAT_AOK;
      pc        <= '0;
      retired   <= '0;
      imem_rd   <= 1'b0;
      imem_addr <= '0;
      dmem_req  <= 1'b0;
      stage_en  <= 5'b00000;
      busy      <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state    <= nxt;
      stat     <= stat_nxt;
      imem_rd  <= fetch_go;
      dmem_req <= dmem_go;
      stage_en <= stage_onehot(nxt);
      busy     <= busy_of(nxt);
      step_q   <= step;
      if (fetch_go) begin
        imem_addr <= fa_sum[ADDR_W-1:0];
      end
      if (pc_load) begin
        pc <= pc_next;
      end
      if (ret_inc) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule
